// File: rtl/uart_program_loader_pkg.sv
// uart_program_loader_pkg
//   State encodings shared by the UART receiver and the program loader.
package uart_program_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_HEADER,
    LD_BODY,
    LD_CHECKSUM,
    LD_DONE,
    LD_ERROR
  } ld_state_t;

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// uart_rx
//   8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and
//   bit counter.
//   Ports:
//     clk, reset        system clock, synchronous active-high reset
//     rx                serial input (idle high, LSB first, async to clk)
//     byte_valid        one-cycle pulse, byte_data holds a good byte
//     byte_data[7:0]    received byte
//     frame_err         one-cycle pulse when the stop bit samples low
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta, rx_sync;
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             byte_valid_next, frame_err_next;

  assign byte_data = shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      state      <= state_next;
      clk_cnt    <= clk_cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      byte_valid <= byte_valid_next;
      frame_err  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state;
    clk_cnt_next    = clk_cnt + 1'b1;
    bit_idx_next    = bit_idx;
    shift_next      = shift;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        clk_cnt_next = '0;
        if (!rx_sync) state_next = RX_START;
      end
      RX_START: begin
        // Half a bit in: a line back high means the falling edge was a glitch.
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_sync, shift[7:1]};
          bit_idx_next = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next    = '0;
          byte_valid_next = rx_sync;
          frame_err_next  = !rx_sync;
          state_next      = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Loads a program image received over UART into the instruction ROM and
//   holds the CPU in reset until the image is complete.
//   Image: word_count N, then N little-endian 32-bit words (plus a 32-bit
//   sum trailer when LOADER_CHECKSUM_EN is defined).
//   Ports:
//     clk, reset        system clock, synchronous active-high reset
//     uart_rx           serial input from the board pin
//     rom_wren          one-cycle ROM write strobe
//     rom_address       word-aligned byte address
//     rom_write_data    instruction word
//     cpu_reset_n       active-low CPU reset, released after a good load
//     load_done         sticky, image fully written
//     load_error        sticky, framing error / oversize / bad checksum
//   Build option: LOADER_CHECKSUM_EN enables the checksum trailer.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT         = 868,
  parameter int ROM_ADDRESS_BITWIDTH = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            uart_rx,
  output logic                            rom_wren,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
  output logic [31:0]                     rom_write_data,
  output logic                            cpu_reset_n,
  output logic                            load_done,
  output logic                            load_error
);

  // Index/count must hold the full capacity value, hence one bit above the word address.
  localparam int          IDX_W     = ROM_ADDRESS_BITWIDTH - 1;
  localparam int unsigned ROM_WORDS = 2 ** (ROM_ADDRESS_BITWIDTH - 2);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Word assembly: only the first three bytes are stored; the fourth is
  // consumed directly so the write can follow it by one cycle.
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic        word_ready;
  logic [31:0] word;

  assign word_ready = byte_valid && (byte_cnt == 2'd3);
  assign word       = {byte_data, word_buf};

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      word_buf <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 1'b1;
      case (byte_cnt)
        2'd0:    word_buf[7:0]   <= byte_data;
        2'd1:    word_buf[15:8]  <= byte_data;
        2'd2:    word_buf[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

  ld_state_t                 ld_state, ld_next;
  logic [IDX_W-1:0]          word_idx, idx_next;
  logic [IDX_W-1:0]          word_count, cnt_next;
  logic                      wren_next;
  logic [ROM_ADDRESS_BITWIDTH-1:0] addr_next;
  logic [31:0]               data_next;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]               sum, sum_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state       <= LD_HEADER;
      word_idx       <= '0;
      word_count     <= '0;
      rom_wren       <= 1'b0;
      rom_address    <= '0;
      rom_write_data <= '0;
      cpu_reset_n    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      ld_state       <= ld_next;
      word_idx       <= idx_next;
      word_count     <= cnt_next;
      rom_wren       <= wren_next;
      rom_address    <= addr_next;
      rom_write_data <= data_next;
      cpu_reset_n    <= (ld_state == LD_DONE);
`ifdef LOADER_CHECKSUM_EN
      sum            <= sum_next;
`endif
    end
  end

  always_comb begin
    ld_next   = ld_state;
    idx_next  = word_idx;
    cnt_next  = word_count;
    wren_next = 1'b0;
    addr_next = rom_address;
    data_next = rom_write_data;
`ifdef LOADER_CHECKSUM_EN
    sum_next  = sum;
`endif
    unique case (ld_state)
      LD_HEADER: begin
        if (frame_err) begin
          ld_next = LD_ERROR;
        end else if (word_ready) begin
          idx_next = '0;
          cnt_next = IDX_W'(word);
`ifdef LOADER_CHECKSUM_EN
          sum_next = '0;
          if (word == 32'd0)                 ld_next = LD_CHECKSUM;
`else
          if (word == 32'd0)                 ld_next = LD_DONE;
`endif
          else if (word > 32'(ROM_WORDS))    ld_next = LD_ERROR;
          else                               ld_next = LD_BODY;
        end
      end
      LD_BODY: begin
        // The final write leaves word_idx == word_count; the state moves on
        // in the cycle after that write.
        if (frame_err) begin
          ld_next = LD_ERROR;
        end else if (word_idx == word_count) begin
`ifdef LOADER_CHECKSUM_EN
          ld_next = LD_CHECKSUM;
`else
          ld_next = LD_DONE;
`endif
        end else if (word_ready) begin
          wren_next = 1'b1;
          data_next = word;
          addr_next = {word_idx[IDX_W-2:0], 2'b00};
          idx_next  = word_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_next  = sum + word;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CHECKSUM: begin
        if (frame_err)       ld_next = LD_ERROR;
        else if (word_ready) ld_next = (word == sum) ? LD_DONE : LD_ERROR;
      end
`endif
      LD_DONE:  ld_next = LD_DONE;
      LD_ERROR: ld_next = LD_ERROR;
      default:  ld_next = LD_ERROR;
    endcase
  end

  assign load_done  = (ld_state == LD_DONE);
  assign load_error = (ld_state == LD_ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
//   Directed and randomized program images sent over the serial line; the
//   observed ROM writes and status flags are compared with a word-level
//   reference model of the loader rules.
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int AW  = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uart_rx = 1'b1;
  logic          rom_wren;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_write_data;
  logic          cpu_reset_n, load_done, load_error;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ROM_ADDRESS_BITWIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .rom_wren      (rom_wren),
    .rom_address   (rom_address),
    .rom_write_data(rom_write_data),
    .cpu_reset_n   (cpu_reset_n),
    .load_done     (load_done),
    .load_error    (load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes and status edges, collected since the last reset.
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int done_cyc = -1;
  int rst_cyc  = -1;

  always @(negedge clk) begin
    if (reset) begin
      wa_q.delete();
      wd_q.delete();
      done_cyc = -1;
      rst_cyc  = -1;
    end else begin
      if (rom_wren) begin
        wa_q.push_back(rom_address);
        wd_q.push_back(rom_write_data);
      end
      if (load_done && done_cyc < 0)   done_cyc = cyc;
      if (cpu_reset_n && rst_cyc < 0)  rst_cyc  = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    check("rst_wren", 32'(rom_wren), 32'd0);
    check("rst_addr", 32'(rom_address), 32'd0);
    check("rst_data", rom_write_data, 32'd0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = !bad_stop;
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB);
  endtask

  // Case description: image words, index of a byte sent with a bad stop bit
  // (-1 for none), and optional line disturbances before the image.
  logic [31:0] img[$];
  int          bad_byte;
  logic        glitch, junk;

  task automatic run_case(input string name);
    logic [AW-1:0] ea[$];
    logic [31:0]   ed[$];
    logic          exp_done, exp_err, stop;
    logic [31:0]   n, sum;
    int            bw, k;

    do_reset();
    if (glitch) begin
      uart_rx = 1'b0;
      tick(4);
      uart_rx = 1'b1;
      tick(3 * CPB);
    end
    if (junk) begin
      // Header plus half a body word, then reset discards the partial word.
      for (int j = 0; j < 4; j++) send_byte(8'(32'd2 >> (8 * j)), 1'b0);
      send_byte(8'h44, 1'b0);
      send_byte(8'h33, 1'b0);
      do_reset();
    end
    k = 0;
    foreach (img[w]) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(8'(img[w] >> (8 * j)), k == bad_byte);
        k++;
      end
    end
    tick(4 * CPB);

    // Reference model at word granularity.
    exp_done = 1'b0;
    exp_err  = 1'b0;
    bw = (bad_byte < 0) ? -1 : bad_byte / 4;
    if (bw == 0) begin
      exp_err = 1'b1;
    end else begin
      n = img[0];
      if (n > 32'd1024) begin
        exp_err = 1'b1;
      end else begin
        sum  = '0;
        stop = 1'b0;
        for (int unsigned i = 0; i < n && !stop; i++) begin
          if (int'(i) + 1 == bw) begin
            exp_err = 1'b1;
            stop = 1'b1;
          end else if (i + 1 >= img.size()) begin
            stop = 1'b1;
          end else begin
            ea.push_back(AW'(i * 4));
            ed.push_back(img[i+1]);
            sum += img[i+1];
          end
        end
        if (!stop) begin
`ifdef LOADER_CHECKSUM_EN
          if (int'(n) + 1 == bw)          exp_err = 1'b1;
          else if (n + 1 < img.size())    begin
            if (img[n+1] == sum) exp_done = 1'b1;
            else                 exp_err  = 1'b1;
          end
`else
          exp_done = 1'b1;
`endif
        end
      end
    end

    check({name, ".nwrites"}, 32'(wa_q.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
      check($sformatf("%s.addr%0d", name, i), 32'(wa_q[i]), 32'(ea[i]));
      check($sformatf("%s.data%0d", name, i), wd_q[i], ed[i]);
    end
    check({name, ".load_done"}, 32'(load_done), 32'(exp_done));
    check({name, ".load_error"}, 32'(load_error), 32'(exp_err));
    check({name, ".cpu_reset_n"}, 32'(cpu_reset_n), 32'(exp_done));
    if (exp_done) check({name, ".rstn_lag"}, 32'(rst_cyc - done_cyc), 32'd1);
  endtask

  task automatic clear_case();
    img.delete();
    bad_byte = -1;
    glitch   = 1'b0;
    junk     = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    int unsigned nb;

    clear_case();
    img = '{32'd2, 32'h0000_0013, 32'h0010_0093};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(32'h0010_00A6);
`endif
    run_case("two_words");

    clear_case();
    img = '{32'd0};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(32'd0);
`endif
    run_case("empty");

    clear_case();
    img = '{32'h0000_0401};
    run_case("oversize");

    clear_case();
    img = '{32'd2, 32'h0000_0013, 32'h0010_0093};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(32'h0010_00A6);
`endif
    bad_byte = 5;
    run_case("bad_stop");

    clear_case();
    img = '{32'd1, 32'hCAFE_F00D};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(32'hCAFE_F00D);
`endif
    glitch = 1'b1;
    run_case("glitch");

    clear_case();
    img = '{32'd1, 32'hDEAD_BEEF};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(32'hDEAD_BEEF);
`endif
    junk = 1'b1;
    run_case("mid_reset");

`ifdef LOADER_CHECKSUM_EN
    clear_case();
    img = '{32'd2, 32'd1, 32'd2, 32'd3};
    run_case("csum_ok");

    clear_case();
    img = '{32'd2, 32'd1, 32'd2, 32'd4};
    run_case("csum_bad");
`endif

    for (int t = 0; t < 8; t++) begin
      clear_case();
      nb = $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0) img.push_back($urandom_range(1025, 32'hFFFF));
      else                           img.push_back(nb);
      s = '0;
      for (int unsigned i = 0; i < nb; i++) begin
        img.push_back($urandom);
        s += img[img.size()-1];
      end
`ifdef LOADER_CHECKSUM_EN
      img.push_back(($urandom_range(0, 2) == 0) ? s + $urandom_range(1, 255) : s);
`endif
      if ($urandom_range(0, 2) == 0) img.push_back($urandom);
      if ($urandom_range(0, 3) == 0) bad_byte = $urandom_range(0, 4 * img.size() - 1);
      glitch = ($urandom_range(0, 3) == 0);
      run_case($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Writer side of the instruction ROM that the CPU core reads through its PC.
- Receives a program image over a UART RX line, assembles little-endian 32-bit words and writes them into the instruction ROM write port.
- Holds the CPU in reset until the image has loaded; releases it on success.
- Sits at the top level between the board RX pin, the ROM write port and the CPU's reset_n.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- ROM_ADDRESS_BITWIDTH, 12, byte-address width of the instruction ROM; capacity is 2^(ROM_ADDRESS_BITWIDTH-2) words.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first; asynchronous to clk.
- rom_wren  out  1  one-cycle write strobe to the instruction ROM.
- rom_address  out  ROM_ADDRESS_BITWIDTH  byte address, word-aligned (bits [1:0]=0).
- rom_write_data  out  32  instruction word.
- cpu_reset_n  out  1  active-low reset to the CPU core; low until the load completes.
- load_done  out  1  sticky; image fully written.
- load_error  out  1  sticky; framing error, oversize image or checksum mismatch.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (port reset).
- Reset: every output is 0. This includes cpu_reset_n=0. The RX FSM goes to RX_IDLE, the loader FSM to LD_HEADER, and all counters clear. A reset mid-frame or mid-image discards partial data; ROM contents already written are left untouched.
- RX synchroniser: two flops on uart_rx, preset to 1. All RX logic uses the synchronised value.
- RX FSM:
  - RX_IDLE -> RX_START on sampled 0.
  - RX_START waits CLKS_PER_BIT/2 cycles, then re-samples. If 1, it is a glitch: back to RX_IDLE. If 0, go to RX_DATA.
  - RX_DATA samples 8 bits, each CLKS_PER_BIT cycles apart, shifted in LSB first.
  - RX_STOP samples after a further CLKS_PER_BIT. If 1, pulse byte_valid for one cycle with the byte. If 0, pulse frame_err for one cycle and drop the byte. Either way, return to RX_IDLE.
- Byte assembly: a 2-bit byte counter. Byte k goes into word bits [8k+7:8k]. The fourth byte completes a word.
- Loader FSM:
  - LD_HEADER: the first word is word_count N (unsigned).
    - N=0 -> LD_DONE.
    - N > 2^(ROM_ADDRESS_BITWIDTH-2) -> LD_ERROR.
    - Otherwise -> LD_BODY with word index 0.
  - LD_BODY: on each completed word, in the next cycle drive rom_wren=1, rom_write_data=word and rom_address=index*4, then increment the index. After word N-1 is written, the next cycle enters LD_DONE.
  - LD_DONE: load_done=1; cpu_reset_n=1, registered, so it rises one cycle after entry. All further RX bytes are ignored and rom_wren stays 0.
  - LD_ERROR: load_error=1 and cpu_reset_n=0. Sticky until reset.
- frame_err in LD_HEADER or LD_BODY -> LD_ERROR.
- No backpressure. The minimum byte spacing (10*CLKS_PER_BIT) always exceeds the one-cycle write.
- Write latency: rom_wren asserts exactly 1 cycle after the byte_valid of a word's fourth byte.
- Address wrap cannot occur because the N limit prevents it.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a 32-bit running sum, modulo 2^32, of all body words.
  - After word N-1, the FSM enters LD_CHECKSUM and expects one further word.
  - Equal to the sum -> LD_DONE. Unequal -> LD_ERROR.
  - For N=0 the checksum word 0x00000000 is still required.
  - The trailer is never written to the ROM.
- Undefined: no trailer and no sum register; LD_BODY goes straight to LD_DONE.

Decomposition:
- define.v gains loader state encodings (LD_HEADER, LD_BODY, LD_CHECKSUM, LD_DONE, LD_ERROR) and RX state encodings.
- One natural sub-module, uart_rx, covering the synchroniser, RX FSM and bit counter. Its outputs are byte_valid, byte_data[7:0] and frame_err.
- Word assembly and the loader FSM stay in uart_program_loader.

Test Plan (CLKS_PER_BIT=16, ROM_ADDRESS_BITWIDTH=12, checksum off unless noted):
- Header 0x00000002 then words 0x00000013, 0x00100093:
  - expect exactly two rom_wren pulses: (addr 0x000, 0x00000013) and (0x004, 0x00100093);
  - load_done=1, then cpu_reset_n=1 one cycle later.
- Header 0x00000000 -> load_done=1, no rom_wren, cpu_reset_n=1.
- Header 0x00000401 (1025 > 1024) -> load_error=1, cpu_reset_n stays 0, no writes.
- Stop bit driven 0 on the second body byte -> load_error=1, no further writes. A 4-cycle low glitch on idle uart_rx produces no byte.
- Reset asserted mid-word after 2 body bytes, then a fresh image 0x00000001, 0xDEADBEEF -> a single write of (0x000, 0xDEADBEEF).
- LOADER_CHECKSUM_EN defined, two words 0x1 and 0x2:
  - trailer 0x00000003 -> load_done=1;
  - trailer 0x00000004 -> load_error=1;
  - in both cases only 2 rom_wren pulses.
